// File: rtl/axis_pkg.sv
// Shared segment definitions for the axis motion path.
// Purpose: one place for segment field widths, the packed 98-bit storage
//   layout and the pack/unpack helpers. The engine and the register file
//   import this package, as does the segment queue.
// Contents:
//   DIR_W / ACC_W / CNT_W  field widths (direction, acceleration, sample counts)
//   SEG_W                  width of one stored segment word
//   *_LSB                  bit offsets of each field inside a segment word
//   segment_t              the segment as a struct
//   seg_pack / seg_unpack  struct <-> storage word conversion
package axis_pkg;

  localparam int DIR_W = 2;
  localparam int ACC_W = 32;
  localparam int CNT_W = 32;
  localparam int SEG_W = DIR_W + ACC_W + 2 * CNT_W;  // 98

  // Storage word layout, LSB first: cruise | accel | acceleration | direction
  localparam int CRUISE_LSB = 0;
  localparam int ACCEL_LSB  = CRUISE_LSB + CNT_W;
  localparam int ACC_LSB    = ACCEL_LSB + CNT_W;
  localparam int DIR_LSB    = ACC_LSB + ACC_W;

  // Fields are kept unsigned here; the signed view of direction and
  // acceleration is applied at the module ports.
  typedef struct packed {
    logic [DIR_W-1:0] direction;
    logic [ACC_W-1:0] acceleration;
    logic [CNT_W-1:0] accel_samples;
    logic [CNT_W-1:0] cruise_samples;
  } segment_t;

  function automatic logic [SEG_W-1:0] seg_pack(input segment_t s);
    logic [SEG_W-1:0] w;
    w = '0;
    w[DIR_LSB    +: DIR_W] = s.direction;
    w[ACC_LSB    +: ACC_W] = s.acceleration;
    w[ACCEL_LSB  +: CNT_W] = s.accel_samples;
    w[CRUISE_LSB +: CNT_W] = s.cruise_samples;
    return w;
  endfunction

  function automatic segment_t seg_unpack(input logic [SEG_W-1:0] w);
    segment_t s;
    s.direction      = w[DIR_LSB    +: DIR_W];
    s.acceleration   = w[ACC_LSB    +: ACC_W];
    s.accel_samples  = w[ACCEL_LSB  +: CNT_W];
    s.cruise_samples = w[CRUISE_LSB +: CNT_W];
    return s;
  endfunction

endpackage

// File: rtl/axis_seg_fifo.sv
// Synchronous segment FIFO with a combinational head read.
// Purpose: holds DEPTH packed segments; the caller decides when a push or
//   pop is legal, this block only moves pointers and the level counter.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, pop       write wr_data / retire the head entry this cycle
//   flush           empty the FIFO (wins over push and pop)
//   wr_data         packed segment to store
//   head_data       entry at the read pointer (valid when !empty)
//   level           entries held, 0..DEPTH
//   full, empty     level == DEPTH / level == 0
module axis_seg_fifo
  import axis_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [SEG_W-1:0]  wr_data,
  output logic [SEG_W-1:0]  head_data,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

  logic [SEG_W-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q,  level_d;

  // Pointers wrap naturally modulo DEPTH because DEPTH is a power of two.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;  // idle, or push+pop cancel out
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state flops take non-blocking assignments so all of them update
    // from pre-edge values, independent of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; only pointers and level
  // define which entries are valid, so stale data is never observable.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign full      = (level_q == FULL_LEVEL);
  assign empty     = (level_q == '0);

endmodule

// File: rtl/axis_segment_queue.sv
// Per-axis segment queue feeding one motion engine.
// Purpose: buffers host-written segments and offers them one at a time on
//   the engine's prgmReq/prgmAck handshake so moves chain back-to-back.
//   Also reports fill level, sticky overflow/starved flags and a wrapping
//   count of segments the engine has taken.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   wrEn, wr*                 push one segment (direction, acceleration,
//                             accel-phase and cruise-phase sample counts)
//   enable                    allow requests to the engine
//   flush                     discard all queued segments
//   clrStatus                 clear overflow / starved
//   level, full, empty        fill status
//   overflow                  sticky: a write was dropped on a full queue
//   starved                   sticky: engine went idle, queue empty, enabled
//   acceptCount               segments taken by the engine (wraps)
//   prgmReq, prgm*            head segment offered to the engine
//   prgmAck                   one-cycle pulse: engine took the head
//   axisBusy                  engine is executing a segment
module axis_segment_queue
  import axis_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrEn,
  input  logic signed [DIR_W-1:0] wrDirection,
  input  logic signed [ACC_W-1:0] wrAcceleration,
  input  logic [CNT_W-1:0]        wrAccelSamples,
  input  logic [CNT_W-1:0]        wrCruiseSamples,
  input  logic                    enable,
  input  logic                    flush,
  input  logic                    clrStatus,
  output logic [ADDR_W:0]         level,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic                    starved,
  output logic [31:0]             acceptCount,
  output logic                    prgmReq,
  input  logic                    prgmAck,
  output logic signed [DIR_W-1:0] prgmDirection,
  output logic signed [ACC_W-1:0] prgmAcceleration,
  output logic [CNT_W-1:0]        prgmAccelSamples,
  output logic [CNT_W-1:0]        prgmCruiseSamples,
  input  logic                    axisBusy
);

  segment_t          wr_seg;
  segment_t          head_seg;
  logic [SEG_W-1:0]  head_word;
  logic [ADDR_W:0]   fifo_level;
  logic              fifo_full;
  logic              fifo_empty;

  logic              pop;
  logic              push;
  logic              overflow_set;
  logic              starved_set;

  logic              prgm_req_q,     prgm_req_d;
  segment_t          prgm_seg_q,     prgm_seg_d;
  logic              overflow_q,     overflow_d;
  logic              starved_q,      starved_d;
  logic              busy_prev_q,    busy_prev_d;
  logic [31:0]       accept_count_q, accept_count_d;

  always_comb begin
    wr_seg.direction      = wrDirection;
    wr_seg.acceleration   = wrAcceleration;
    wr_seg.accel_samples  = wrAccelSamples;
    wr_seg.cruise_samples = wrCruiseSamples;
  end

  axis_seg_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .wr_data   (seg_pack(wr_seg)),
    .head_data (head_word),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign head_seg = seg_unpack(head_word);

  // An ack only counts while a request is actually outstanding; a stray ack
  // (e.g. one arriving just after reset) neither pops nor counts.
  // A full queue still takes a write when the head leaves in the same cycle.
  always_comb begin
    pop          = prgmAck && prgm_req_q;
    push         = wrEn && !flush && (!fifo_full || pop);
    overflow_set = wrEn && !flush && fifo_full && !pop;
    starved_set  = busy_prev_q && !axisBusy && fifo_empty && enable;
  end

  // Request/field next state. The request uses the registered empty flag, so
  // a push into an empty queue raises prgmReq one edge after the push, and an
  // ack leaves prgmReq low for exactly one cycle. Fields only reload on
  // non-ack edges, when the read pointer is stable, so they cannot move
  // while prgmReq is high.
  always_comb begin
    prgm_req_d = prgm_req_q;
    prgm_seg_d = prgm_seg_q;
    if (pop) begin
      prgm_req_d = 1'b0;
    end else begin
      prgm_req_d = enable && !fifo_empty && !flush;
      prgm_seg_d = head_seg;
    end
  end

  // Status next state: a set in the same cycle beats clrStatus.
  always_comb begin
    overflow_d     = overflow_q;
    starved_d      = starved_q;
    if (overflow_set)   overflow_d = 1'b1;
    else if (clrStatus) overflow_d = 1'b0;
    if (starved_set)    starved_d  = 1'b1;
    else if (clrStatus) starved_d  = 1'b0;
    accept_count_d = pop ? accept_count_q + 32'd1 : accept_count_q;
    busy_prev_d    = axisBusy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prgm_req_q     <= 1'b0;
      prgm_seg_q     <= '0;
      overflow_q     <= 1'b0;
      starved_q      <= 1'b0;
      accept_count_q <= '0;
      busy_prev_q    <= 1'b0;
    end else begin
      prgm_req_q     <= prgm_req_d;
      prgm_seg_q     <= prgm_seg_d;
      overflow_q     <= overflow_d;
      starved_q      <= starved_d;
      accept_count_q <= accept_count_d;
      busy_prev_q    <= busy_prev_d;
    end
  end

  assign level             = fifo_level;
  assign full              = fifo_full;
  assign empty             = fifo_empty;
  assign overflow          = overflow_q;
  assign starved           = starved_q;
  assign acceptCount       = accept_count_q;
  assign prgmReq           = prgm_req_q;
  assign prgmDirection     = prgm_seg_q.direction;
  assign prgmAcceleration  = prgm_seg_q.acceleration;
  assign prgmAccelSamples  = prgm_seg_q.accel_samples;
  assign prgmCruiseSamples = prgm_seg_q.cruise_samples;

endmodule

// File: tb/tb_axis_segment_queue.sv
// Self-checking bench for axis_segment_queue: directed scenarios followed by
// a randomized run, all compared every cycle against a queue-based model.
module tb_axis_segment_queue;
  import axis_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CLK_HALF = 5;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    wrEn = 1'b0;
  logic signed [DIR_W-1:0] wrDirection = '0;
  logic signed [ACC_W-1:0] wrAcceleration = '0;
  logic [CNT_W-1:0]        wrAccelSamples = '0;
  logic [CNT_W-1:0]        wrCruiseSamples = '0;
  logic                    enable = 1'b0;
  logic                    flush = 1'b0;
  logic                    clrStatus = 1'b0;
  logic [ADDR_W:0]         level;
  logic                    full;
  logic                    empty;
  logic                    overflow;
  logic                    starved;
  logic [31:0]             acceptCount;
  logic                    prgmReq;
  logic                    prgmAck = 1'b0;
  logic signed [DIR_W-1:0] prgmDirection;
  logic signed [ACC_W-1:0] prgmAcceleration;
  logic [CNT_W-1:0]        prgmAccelSamples;
  logic [CNT_W-1:0]        prgmCruiseSamples;
  logic                    axisBusy = 1'b0;

  axis_segment_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .wrEn              (wrEn),
    .wrDirection       (wrDirection),
    .wrAcceleration    (wrAcceleration),
    .wrAccelSamples    (wrAccelSamples),
    .wrCruiseSamples   (wrCruiseSamples),
    .enable            (enable),
    .flush             (flush),
    .clrStatus         (clrStatus),
    .level             (level),
    .full              (full),
    .empty             (empty),
    .overflow          (overflow),
    .starved           (starved),
    .acceptCount       (acceptCount),
    .prgmReq           (prgmReq),
    .prgmAck           (prgmAck),
    .prgmDirection     (prgmDirection),
    .prgmAcceleration  (prgmAcceleration),
    .prgmAccelSamples  (prgmAccelSamples),
    .prgmCruiseSamples (prgmCruiseSamples),
    .axisBusy          (axisBusy)
  );

  always #CLK_HALF clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The queue is a plain SV queue; prgmReq and the status flags follow the
  // handshake rules directly from the pre-edge state and inputs.
  segment_t    m_q[$];
  bit          m_valid = 0;
  bit          m_req = 0;
  bit          m_ovf = 0;
  bit          m_starved = 0;
  bit          m_busy_prev = 0;
  logic [31:0] m_acc = '0;

  always @(posedge clk) begin
    bit       pop, was_full, was_empty, ovf_set, starve_set;
    segment_t s;
    if (rst) begin
      m_q.delete();
      m_req = 0; m_ovf = 0; m_starved = 0; m_busy_prev = 0; m_acc = '0;
      m_valid = 1;
    end else begin
      pop        = prgmAck && m_req;
      was_full   = (m_q.size() == DEPTH);
      was_empty  = (m_q.size() == 0);
      ovf_set    = wrEn && !flush && was_full && !pop;
      starve_set = m_busy_prev && !axisBusy && was_empty && enable;
      s.direction      = wrDirection;
      s.acceleration   = wrAcceleration;
      s.accel_samples  = wrAccelSamples;
      s.cruise_samples = wrCruiseSamples;
      if (pop) m_acc = m_acc + 1;
      if (flush) m_q.delete();
      else begin
        if (pop) void'(m_q.pop_front());
        if (wrEn && (!was_full || pop)) m_q.push_back(s);
      end
      m_req = pop ? 0 : (enable && !was_empty && !flush);
      if (ovf_set) m_ovf = 1; else if (clrStatus) m_ovf = 0;
      if (starve_set) m_starved = 1; else if (clrStatus) m_starved = 0;
      m_busy_prev = axisBusy;
    end
  end

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("level",       level,       m_q.size());
      check("full",        full,        m_q.size() == DEPTH);
      check("empty",       empty,       m_q.size() == 0);
      check("overflow",    overflow,    m_ovf);
      check("starved",     starved,     m_starved);
      check("acceptCount", acceptCount, m_acc);
      check("prgmReq",     prgmReq,     m_req);
      if (m_req && m_q.size() != 0) begin
        check("prgmDirection",     $unsigned(prgmDirection),    m_q[0].direction);
        check("prgmAcceleration",  $unsigned(prgmAcceleration), m_q[0].acceleration);
        check("prgmAccelSamples",  prgmAccelSamples,  m_q[0].accel_samples);
        check("prgmCruiseSamples", prgmCruiseSamples, m_q[0].cruise_samples);
      end
    end
  end

  // ---------------- engine stimulus ----------------
  // Acks on phase 4 of a free-running 4-cycle phase, only when idle, then
  // stays busy for a while. Optionally throws in stray acks while no request.
  bit eng_on = 0;
  bit spurious = 0;
  bit ack_real = 0;
  int fixed_len = 0;
  int busy_cnt = 0;
  int phase = 0;

  function automatic int eng_len();
    return (fixed_len != 0) ? fixed_len : int'($urandom_range(1, 6));
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
    if (eng_on) begin
      phase = (phase + 1) % 4;
      if (prgmAck) begin
        prgmAck = 1'b0;
        if (ack_real) busy_cnt = eng_len();
        ack_real = 0;
      end else if (busy_cnt != 0) begin
        busy_cnt--;
      end
      axisBusy = (busy_cnt != 0);
      if (!axisBusy && prgmReq && phase == 3) begin
        prgmAck = 1'b1;
        ack_real = 1;
      end else if (spurious && !prgmReq && $urandom_range(0, 9) == 0) begin
        prgmAck = 1'b1;
        ack_real = 0;
      end
    end
  endtask

  task automatic set_seg(input logic [1:0] d, input logic [31:0] a,
                         input logic [31:0] n_acc, input logic [31:0] n_cru);
    wrDirection     = d;
    wrAcceleration  = a;
    wrAccelSamples  = n_acc;
    wrCruiseSamples = n_cru;
  endtask

  // Let the engine finish its current segment, then take it off the bus.
  task automatic engine_quiesce();
    for (int i = 0; i < 100; i++) begin
      if (busy_cnt == 0 && !prgmAck) break;
      tick();
    end
    check("engine_quiesce", (busy_cnt == 0 && !prgmAck), 1'b1);
    eng_on = 0; ack_real = 0; prgmAck = 1'b0; axisBusy = 1'b0;
  endtask

  initial begin
    #(2 * CLK_HALF * 60000);
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] acc_base;

    // --- reset state ---
    rst = 1'b1;
    tick(); tick();
    check("rst_level",   level, 0);
    check("rst_empty",   empty, 1);
    check("rst_full",    full, 0);
    check("rst_prgmReq", prgmReq, 0);
    check("rst_fields",  {prgmDirection, prgmAcceleration, prgmAccelSamples, prgmCruiseSamples}, 0);
    check("rst_accept",  acceptCount, 0);
    check("rst_flags",   {overflow, starved}, 0);
    rst = 1'b0;

    // --- three segments, engine acks on phase 4 when idle ---
    enable = 1'b1; eng_on = 1; spurious = 0; fixed_len = 6; phase = 0;
    set_seg(2'b01, 32'h100, 32'd10, 32'd5);
    wrEn = 1'b1;
    tick();
    check("latency_push_edge", prgmReq, 0);
    tick();
    check("latency_req_edge", prgmReq, 1);
    check("seg1_accel",  prgmAccelSamples, 32'd10);
    check("seg1_acc",    $unsigned(prgmAcceleration), 32'h100);
    check("seg1_dir",    $unsigned(prgmDirection), 2'b01);
    tick();
    wrEn = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (acceptCount == 3 && busy_cnt == 0) break;
    end
    tick();
    check("three_accepted", acceptCount, 3);
    check("three_empty",    empty, 1);
    check("starved_set",    starved, 1);
    clrStatus = 1'b1; tick(); clrStatus = 1'b0;
    check("starved_clr",    starved, 0);

    // --- same completion with enable low: no starvation ---
    wrEn = 1'b1; tick(); wrEn = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (acceptCount == 4) break;
      tick();
    end
    enable = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy_cnt == 0) break;
      tick();
    end
    tick(); tick();
    check("starved_disabled", starved, 0);
    engine_quiesce();

    // --- overflow: 17 writes, enable low ---
    for (int i = 0; i < 17; i++) begin
      set_seg(2'b11, 32'hFFFF_FF00 + i, 32'd100 + i, i);
      wrEn = 1'b1;
      tick();
    end
    wrEn = 1'b0;
    check("ovf_level",    level, 16);
    check("ovf_full",     full, 1);
    check("ovf_overflow", overflow, 1);
    clrStatus = 1'b1; tick(); clrStatus = 1'b0;
    check("ovf_clr", overflow, 0);

    // --- full queue, write and ack in the same cycle ---
    enable = 1'b1;
    tick();
    check("full_req",        prgmReq, 1);
    check("full_head_first", prgmCruiseSamples, 0);
    set_seg(2'b01, 32'd7, 32'd8, 32'd99);
    wrEn = 1'b1; prgmAck = 1'b1;
    tick();
    wrEn = 1'b0; prgmAck = 1'b0;
    check("pushpop_level",    level, 16);
    check("pushpop_overflow", overflow, 0);
    check("pushpop_accept",   acceptCount, 5);
    tick();
    check("pushpop_next_head", prgmCruiseSamples, 1);
    // drain in order; the dropped 17th entry never appears
    eng_on = 1; fixed_len = 1;
    for (int i = 0; i < 400; i++) begin
      if (acceptCount == 21) break;
      tick();
    end
    check("drain_accept", acceptCount, 21);
    engine_quiesce();

    // --- flush with coincident write and ack ---
    enable = 1'b0;
    clrStatus = 1'b1; tick(); clrStatus = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_seg(2'b00, i, i, i);
      wrEn = 1'b1; tick();
    end
    wrEn = 1'b0;
    enable = 1'b1;
    tick();
    check("flush_req_before", prgmReq, 1);
    acc_base = acceptCount;
    wrEn = 1'b1; prgmAck = 1'b1; flush = 1'b1;
    tick();
    wrEn = 1'b0; prgmAck = 1'b0; flush = 1'b0;
    check("flush_level",    level, 0);
    check("flush_req",      prgmReq, 0);
    check("flush_accept",   acceptCount, acc_base + 1);
    check("flush_overflow", overflow, 0);
    tick();
    check("flush_req_after", prgmReq, 0);

    // --- reset mid-handshake, stray ack after release ---
    set_seg(2'b01, 1, 2, 3);
    wrEn = 1'b1; tick(); tick(); wrEn = 1'b0;
    tick();
    check("prereset_req", prgmReq, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    tick();
    prgmAck = 1'b1; tick(); prgmAck = 1'b0;
    tick();
    check("postreset_accept", acceptCount, 0);
    check("postreset_level",  level, 0);
    check("postreset_req",    prgmReq, 0);

    // --- randomized traffic ---
    eng_on = 1; spurious = 1; fixed_len = 0; busy_cnt = 0;
    phase = int'($urandom_range(0, 3));
    for (int i = 0; i < 3000; i++) begin
      wrEn      = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      set_seg(2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
      enable    = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 99) == 0);
      clrStatus = ($urandom_range(0, 31) == 0);
      tick();
    end
    wrEn = 1'b0; flush = 1'b0; clrStatus = 1'b0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
